alt_mem_ddrx_itf_master: RTL and testbench

- Local-side initiator for the controller's native itf_* interface.
- Accepts simple user read/write requests and drives the command channel, then the write-data beats.
- Tracks outstanding reads and returns read data to the user with ID and error status.
- Sits between a user traffic source (test driver or bridge) and the controller input interface.

---
 rtl/alt_mem_ddrx_itf_master_if.sv | 87 ++++++++
 rtl/alt_mem_ddrx_itf_master.sv | 172 +++++++++++++++++
 tb/tb_alt_mem_ddrx_itf_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_mem_ddrx_itf_master_if.sv
// Signal bundle between the local-side initiator and its neighbours: user request,
// write-data and read-return channels plus the controller's native itf_* channels.
interface alt_mem_ddrx_itf_master_if #(
    parameter int CFG_LOCAL_DATA_WIDTH = 64,
    parameter int CFG_LOCAL_ID_WIDTH   = 8,
    parameter int CFG_LOCAL_ADDR_WIDTH = 33,
    parameter int CFG_LOCAL_SIZE_WIDTH = 3
);
    localparam int BE_W = CFG_LOCAL_DATA_WIDTH / 8;

    logic                            usr_req_valid;
    logic                            usr_req_ready;
    logic                            usr_req_write;
    logic [CFG_LOCAL_ADDR_WIDTH-1:0] usr_req_addr;
    logic [CFG_LOCAL_SIZE_WIDTH-1:0] usr_req_size;

    logic                            usr_wdata_valid;
    logic                            usr_wdata_ready;
    logic [CFG_LOCAL_DATA_WIDTH-1:0] usr_wdata;
    logic [BE_W-1:0]                 usr_wdata_be;

    logic                            itf_cmd_valid;
    logic                            itf_cmd_ready;
    logic                            itf_cmd;
    logic [CFG_LOCAL_ADDR_WIDTH-1:0] itf_cmd_address;
    logic [CFG_LOCAL_SIZE_WIDTH-1:0] itf_cmd_burstlen;
    logic [CFG_LOCAL_ID_WIDTH-1:0]   itf_cmd_id;
    logic                            itf_cmd_priority;
    logic                            itf_cmd_autopercharge;
    logic                            itf_cmd_multicast;

    logic                            itf_wr_data_valid;
    logic                            itf_wr_data_ready;
    logic [CFG_LOCAL_DATA_WIDTH-1:0] itf_wr_data;
    logic [BE_W-1:0]                 itf_wr_data_byte_en;
    logic                            itf_wr_data_begin;
    logic                            itf_wr_data_last;
    logic [CFG_LOCAL_ID_WIDTH-1:0]   itf_wr_data_id;

    logic                            itf_rd_data_ready;
    logic                            itf_rd_data_valid;
    logic                            itf_rd_data_error;
    logic                            itf_rd_data_begin;
    logic                            itf_rd_data_last;
    logic [CFG_LOCAL_DATA_WIDTH-1:0] itf_rd_data;
    logic [CFG_LOCAL_ID_WIDTH-1:0]   itf_rd_data_id;

    logic                            usr_rdata_valid;
    logic                            usr_rdata_error;
    logic                            usr_rdata_last;
    logic [CFG_LOCAL_DATA_WIDTH-1:0] usr_rdata;
    logic [CFG_LOCAL_ID_WIDTH-1:0]   usr_rdata_id;

    modport master (
        input  usr_req_valid, usr_req_write, usr_req_addr, usr_req_size,
        output usr_req_ready,
        input  usr_wdata_valid, usr_wdata, usr_wdata_be,
        output usr_wdata_ready,
        output itf_cmd_valid, itf_cmd, itf_cmd_address, itf_cmd_burstlen, itf_cmd_id,
        output itf_cmd_priority, itf_cmd_autopercharge, itf_cmd_multicast,
        input  itf_cmd_ready,
        output itf_wr_data_valid, itf_wr_data, itf_wr_data_byte_en,
        output itf_wr_data_begin, itf_wr_data_last, itf_wr_data_id,
        input  itf_wr_data_ready,
        output itf_rd_data_ready,
        input  itf_rd_data_valid, itf_rd_data_error, itf_rd_data_begin, itf_rd_data_last,
        input  itf_rd_data, itf_rd_data_id,
        output usr_rdata_valid, usr_rdata_error, usr_rdata_last, usr_rdata, usr_rdata_id
    );

    modport slave (
        output usr_req_valid, usr_req_write, usr_req_addr, usr_req_size,
        input  usr_req_ready,
        output usr_wdata_valid, usr_wdata, usr_wdata_be,
        input  usr_wdata_ready,
        input  itf_cmd_valid, itf_cmd, itf_cmd_address, itf_cmd_burstlen, itf_cmd_id,
        input  itf_cmd_priority, itf_cmd_autopercharge, itf_cmd_multicast,
        output itf_cmd_ready,
        input  itf_wr_data_valid, itf_wr_data, itf_wr_data_byte_en,
        input  itf_wr_data_begin, itf_wr_data_last, itf_wr_data_id,
        output itf_wr_data_ready,
        input  itf_rd_data_ready,
        output itf_rd_data_valid, itf_rd_data_error, itf_rd_data_begin, itf_rd_data_last,
        output itf_rd_data, itf_rd_data_id,
        input  usr_rdata_valid, usr_rdata_error, usr_rdata_last, usr_rdata, usr_rdata_id
    );
endinterface

// File: rtl/alt_mem_ddrx_itf_master.sv
// Local-side initiator: turns simple user read/write requests into itf_* commands and
// write bursts, tracks outstanding reads and forwards read beats back to the user.
module alt_mem_ddrx_itf_master #(
    parameter int CFG_LOCAL_DATA_WIDTH   = 64,
    parameter int CFG_LOCAL_ID_WIDTH     = 8,
    parameter int CFG_LOCAL_ADDR_WIDTH   = 33,
    parameter int CFG_LOCAL_SIZE_WIDTH   = 3,
    parameter int CFG_MAX_RD_OUTSTANDING = 8
) (
    input  logic                      ctl_clk,
    input  logic                      ctl_reset,
    input  logic                      local_init_done,
    alt_mem_ddrx_itf_master_if.master bus,
    output logic [7:0]                rd_outstanding,
    output logic                      proto_err
);
    localparam int DW   = CFG_LOCAL_DATA_WIDTH;
    localparam int IW   = CFG_LOCAL_ID_WIDTH;
    localparam int AW   = CFG_LOCAL_ADDR_WIDTH;
    localparam int SW   = CFG_LOCAL_SIZE_WIDTH;
    localparam int BE_W = DW / 8;

    localparam logic [SW-1:0] ONE_BEAT = SW'(1);
    localparam logic [IW-1:0] ID_STEP  = IW'(1);
    localparam logic [7:0]    RD_STEP  = 8'd1;
    localparam logic [8:0]    MAX_RD   = 9'(CFG_MAX_RD_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

    state_t          state_q, state_d;
    logic            active_q;
    logic            cmd_write_q;
    logic [AW-1:0]   cmd_addr_q;
    logic [SW-1:0]   cmd_size_q;
    logic [IW-1:0]   cmd_id_q;
    logic [IW-1:0]   id_cnt_q;
    logic [SW-1:0]   beat_cnt_q;
    logic            first_beat_q;
    logic [7:0]      rd_cnt_q;
    logic            proto_err_q;
    logic            rd_burst_q;
    logic            rdata_vld_q;
    logic [DW-1:0]   rdata_q;
    logic [IW-1:0]   rdata_id_q;
    logic            rdata_err_q;
    logic            rdata_last_q;

    logic req_ready, req_acc, size_zero, cmd_hs, in_wdata, wr_xfer, wr_last;
    logic rd_beat, rd_inc, rd_dec, rd_viol;

    // active_q holds off all handshakes until the first clock edge after reset release
    assign req_ready = active_q && (state_q == IDLE) && local_init_done &&
                       (bus.usr_req_write || ({1'b0, rd_cnt_q} < MAX_RD));
    assign req_acc   = bus.usr_req_valid && req_ready;
    assign size_zero = (bus.usr_req_size == '0);
    assign cmd_hs    = (state_q == CMD) && bus.itf_cmd_ready;
    assign in_wdata  = (state_q == WDATA);
    assign wr_last   = (beat_cnt_q == ONE_BEAT);
    assign wr_xfer   = in_wdata && bus.usr_wdata_valid && bus.itf_wr_data_ready;

    assign rd_beat = active_q && bus.itf_rd_data_valid;
    assign rd_inc  = cmd_hs && !cmd_write_q;
    assign rd_dec  = rd_beat && bus.itf_rd_data_last && (rd_cnt_q != '0);
    assign rd_viol = rd_beat && ((rd_cnt_q == '0) ||
                                 ( bus.itf_rd_data_begin &&  rd_burst_q) ||
                                 (!bus.itf_rd_data_begin && !rd_burst_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_acc && !size_zero) state_d = CMD;
            CMD:     if (cmd_hs) state_d = cmd_write_q ? WDATA : IDLE;
            WDATA:   if (wr_xfer && wr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            active_q     <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_size_q   <= '0;
            cmd_id_q     <= '0;
            id_cnt_q     <= '0;
            beat_cnt_q   <= '0;
            first_beat_q <= 1'b0;
            rd_cnt_q     <= '0;
            proto_err_q  <= 1'b0;
            rd_burst_q   <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (req_acc && !size_zero) begin
                cmd_write_q <= bus.usr_req_write;
                cmd_addr_q  <= bus.usr_req_addr;
                cmd_size_q  <= bus.usr_req_size;
                cmd_id_q    <= id_cnt_q;
                id_cnt_q    <= id_cnt_q + ID_STEP;
            end
            if (cmd_hs && cmd_write_q) begin
                beat_cnt_q   <= cmd_size_q;
                first_beat_q <= 1'b1;
            end else if (wr_xfer) begin
                beat_cnt_q   <= beat_cnt_q - ONE_BEAT;
                first_beat_q <= 1'b0;
            end
            // a command launch and a closing read beat in the same cycle cancel out
            case ({rd_inc, rd_dec})
                2'b10:   rd_cnt_q <= rd_cnt_q + RD_STEP;
                2'b01:   rd_cnt_q <= rd_cnt_q - RD_STEP;
                default: rd_cnt_q <= rd_cnt_q;
            endcase
            if (rd_beat) rd_burst_q <= !bus.itf_rd_data_last;
            if (rd_viol || (req_acc && size_zero)) proto_err_q <= 1'b1;
        end
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            rdata_vld_q  <= 1'b0;
            rdata_q      <= '0;
            rdata_id_q   <= '0;
            rdata_err_q  <= 1'b0;
            rdata_last_q <= 1'b0;
        end else begin
            rdata_vld_q <= rd_beat;
            if (rd_beat) begin
                rdata_q      <= bus.itf_rd_data;
                rdata_id_q   <= bus.itf_rd_data_id;
                rdata_err_q  <= bus.itf_rd_data_error;
                rdata_last_q <= bus.itf_rd_data_last;
            end
        end
    end

    assign bus.usr_req_ready         = req_ready;
    assign bus.itf_cmd_valid         = (state_q == CMD);
    assign bus.itf_cmd               = cmd_write_q;
    assign bus.itf_cmd_address       = cmd_addr_q;
    assign bus.itf_cmd_burstlen      = cmd_size_q;
    assign bus.itf_cmd_id            = cmd_id_q;
    assign bus.itf_cmd_priority      = 1'b0;
    assign bus.itf_cmd_autopercharge = 1'b0;
    assign bus.itf_cmd_multicast     = 1'b0;

    // write channel is a combinational pass-through while a burst is owned
    assign bus.usr_wdata_ready     = in_wdata && bus.itf_wr_data_ready;
    assign bus.itf_wr_data_valid   = in_wdata && bus.usr_wdata_valid;
    assign bus.itf_wr_data         = in_wdata ? bus.usr_wdata : '0;
    assign bus.itf_wr_data_byte_en = in_wdata ? bus.usr_wdata_be : {BE_W{1'b0}};
    assign bus.itf_wr_data_begin   = in_wdata && first_beat_q;
    assign bus.itf_wr_data_last    = in_wdata && wr_last;
    assign bus.itf_wr_data_id      = in_wdata ? cmd_id_q : '0;

    assign bus.itf_rd_data_ready = active_q;
    assign bus.usr_rdata_valid   = rdata_vld_q;
    assign bus.usr_rdata         = rdata_q;
    assign bus.usr_rdata_id      = rdata_id_q;
    assign bus.usr_rdata_error   = rdata_err_q;
    assign bus.usr_rdata_last    = rdata_last_q;

    assign rd_outstanding = rd_cnt_q;
    assign proto_err      = proto_err_q;
endmodule

// File: tb/tb_alt_mem_ddrx_itf_master.sv
// Directed bench for alt_mem_ddrx_itf_master with two read commands allowed in flight.
module tb_alt_mem_ddrx_itf_master;
    localparam int DW = 64;
    localparam int IW = 8;
    localparam int AW = 33;
    localparam int SW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic [7:0] rd_outstanding;
    logic       proto_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_id   = 8'd0;

    alt_mem_ddrx_itf_master_if #(
        .CFG_LOCAL_DATA_WIDTH(DW), .CFG_LOCAL_ID_WIDTH(IW),
        .CFG_LOCAL_ADDR_WIDTH(AW), .CFG_LOCAL_SIZE_WIDTH(SW)
    ) bus ();

    alt_mem_ddrx_itf_master #(
        .CFG_LOCAL_DATA_WIDTH(DW), .CFG_LOCAL_ID_WIDTH(IW),
        .CFG_LOCAL_ADDR_WIDTH(AW), .CFG_LOCAL_SIZE_WIDTH(SW),
        .CFG_MAX_RD_OUTSTANDING(2)
    ) dut (
        .ctl_clk(clk),
        .ctl_reset(rst),
        .local_init_done(init_done),
        .bus(bus),
        .rd_outstanding(rd_outstanding),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // present a request and hold it until accepted; returns 1 ns after the accept edge
    task automatic req(input logic wr, input logic [AW-1:0] addr, input logic [SW-1:0] size);
        int n;
        @(negedge clk);
        bus.usr_req_valid = 1'b1;
        bus.usr_req_write = wr;
        bus.usr_req_addr  = addr;
        bus.usr_req_size  = size;
        n = 0;
        #1;
        while (!bus.usr_req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_val("req_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.usr_req_valid = 1'b0;
    endtask

    task automatic cmd_expect(input logic wr, input logic [AW-1:0] addr, input logic [SW-1:0] size);
        check_val("cmd_valid", bus.itf_cmd_valid, 1);
        check_val("cmd_write", bus.itf_cmd, wr);
        check_val("cmd_addr", bus.itf_cmd_address, addr);
        check_val("cmd_len", bus.itf_cmd_burstlen, size);
        check_val("cmd_id", bus.itf_cmd_id, exp_id);
    endtask

    task automatic cmd_take();
        bus.itf_cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.itf_cmd_ready = 1'b0;
        exp_id++;
        check_val("cmd_done", bus.itf_cmd_valid, 0);
    endtask

    task automatic wbeats(input int n, input bit toggle, input logic [IW-1:0] id);
        int  i = 0;
        int  guard = 0;
        bit  rdy = 1'b1;
        while (i < n && guard < 40) begin
            @(negedge clk);
            bus.usr_wdata_valid   = 1'b1;
            bus.usr_wdata         = 64'hA5A5_0000_0000_0000 + 64'(i);
            bus.usr_wdata_be      = 8'hF0 ^ 8'(i);
            bus.itf_wr_data_ready = toggle ? rdy : 1'b1;
            rdy = !rdy;
            #1;
            check_val("wr_ready_track", bus.usr_wdata_ready, bus.itf_wr_data_ready);
            check_val("wr_valid", bus.itf_wr_data_valid, 1);
            if (bus.itf_wr_data_ready) begin
                check_val("wr_begin", bus.itf_wr_data_begin, (i == 0));
                check_val("wr_last", bus.itf_wr_data_last, (i == n - 1));
                check_val("wr_id", bus.itf_wr_data_id, id);
                check_val("wr_data", bus.itf_wr_data, 64'hA5A5_0000_0000_0000 + 64'(i));
                check_val("wr_be", bus.itf_wr_data_byte_en, 8'hF0 ^ 8'(i));
                i++;
            end
            guard++;
        end
        if (guard >= 40) check_val("wr_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.usr_wdata_valid   = 1'b0;
        bus.itf_wr_data_ready = 1'b1;
        #1;
        check_val("wr_closed_ready", bus.usr_wdata_ready, 0);
        check_val("wr_closed_valid", bus.itf_wr_data_valid, 0);
        bus.itf_wr_data_ready = 1'b0;
    endtask

    task automatic rbeat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                         input logic bgn, input logic last, input logic err);
        @(negedge clk);
        bus.itf_rd_data_valid = 1'b1;
        bus.itf_rd_data_id    = id;
        bus.itf_rd_data       = data;
        bus.itf_rd_data_begin = bgn;
        bus.itf_rd_data_last  = last;
        bus.itf_rd_data_error = err;
        @(posedge clk);
        #1;
        bus.itf_rd_data_valid = 1'b0;
        check_val("rdata_valid", bus.usr_rdata_valid, 1);
        check_val("rdata", bus.usr_rdata, data);
        check_val("rdata_id", bus.usr_rdata_id, id);
        check_val("rdata_last", bus.usr_rdata_last, last);
        check_val("rdata_err", bus.usr_rdata_error, err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.usr_req_valid = 0; bus.usr_req_write = 0; bus.usr_req_addr = '0; bus.usr_req_size = '0;
        bus.usr_wdata_valid = 0; bus.usr_wdata = '0; bus.usr_wdata_be = '0;
        bus.itf_cmd_ready = 0; bus.itf_wr_data_ready = 0;
        bus.itf_rd_data_valid = 0; bus.itf_rd_data_error = 0; bus.itf_rd_data_begin = 0;
        bus.itf_rd_data_last = 0; bus.itf_rd_data = '0; bus.itf_rd_data_id = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cmd_valid", bus.itf_cmd_valid, 0);
        check_val("rst_rd_ready", bus.itf_rd_data_ready, 0);
        check_val("rst_rdata_valid", bus.usr_rdata_valid, 0);
        check_val("rst_rd_out", rd_outstanding, 0);
        check_val("rst_proto_err", proto_err, 0);
        check_val("rst_req_ready", bus.usr_req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rd_ready_rise", bus.itf_rd_data_ready, 1);

        // blocked by init_done, then write 0x100 size 4 with a stalled command
        @(negedge clk);
        bus.usr_req_valid = 1; bus.usr_req_write = 1; bus.usr_req_addr = 33'h100; bus.usr_req_size = 3'd4;
        repeat (3) begin
            #1;
            check_val("noinit_ready", bus.usr_req_ready, 0);
            check_val("noinit_cmd", bus.itf_cmd_valid, 0);
            @(negedge clk);
        end
        init_done = 1'b1;
        #1;
        check_val("init_ready", bus.usr_req_ready, 1);
        @(posedge clk);
        #1;
        bus.usr_req_valid = 0;
        cmd_expect(1, 33'h100, 3'd4);
        repeat (3) @(posedge clk);
        #1;
        cmd_expect(1, 33'h100, 3'd4);
        check_val("busy_ready", bus.usr_req_ready, 0);
        cmd_take();
        wbeats(4, 1'b0, 8'd0);
        check_val("idle_after_wr", bus.usr_req_ready, 1);

        // size-3 write with toggling controller ready
        req(1, 33'h200, 3'd3);
        cmd_expect(1, 33'h200, 3'd3);
        cmd_take();
        wbeats(3, 1'b1, 8'd1);

        // two reads fill the outstanding limit; the third waits for a return
        req(0, 33'h300, 3'd2);
        cmd_expect(0, 33'h300, 3'd2);
        cmd_take();
        check_val("rd_out_1", rd_outstanding, 1);
        req(0, 33'h340, 3'd1);
        cmd_expect(0, 33'h340, 3'd1);
        cmd_take();
        check_val("rd_out_2", rd_outstanding, 2);
        @(negedge clk);
        bus.usr_req_valid = 1; bus.usr_req_write = 0; bus.usr_req_addr = 33'h380; bus.usr_req_size = 3'd1;
        repeat (2) begin
            #1;
            check_val("rd_block_ready", bus.usr_req_ready, 0);
            @(negedge clk);
        end
        check_val("rd_block_cmd", bus.itf_cmd_valid, 0);
        check_val("rd_out_full", rd_outstanding, 2);
        rbeat(8'd2, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0);
        check_val("rd_out_midburst", rd_outstanding, 2);
        rbeat(8'd2, 64'h5555_6666_7777_8888, 1'b0, 1'b1, 1'b1);
        check_val("rd_out_ret", rd_outstanding, 1);
        check_val("rd_unblock_ready", bus.usr_req_ready, 1);
        @(posedge clk);
        #1;
        bus.usr_req_valid = 0;
        cmd_expect(0, 33'h380, 3'd1);
        cmd_take();
        check_val("rd_out_refill", rd_outstanding, 2);
        rbeat(8'd3, 64'hDEAD_BEEF_0000_0003, 1'b1, 1'b1, 1'b0);
        check_val("rd_out_after3", rd_outstanding, 1);

        // command launch coincides with the closing beat of the older read
        req(0, 33'h500, 3'd1);
        cmd_expect(0, 33'h500, 3'd1);
        bus.itf_cmd_ready = 1;
        bus.itf_rd_data_valid = 1; bus.itf_rd_data_id = 8'd4; bus.itf_rd_data = 64'h44;
        bus.itf_rd_data_begin = 1; bus.itf_rd_data_last = 1; bus.itf_rd_data_error = 0;
        @(posedge clk);
        #1;
        bus.itf_cmd_ready = 0;
        bus.itf_rd_data_valid = 0;
        exp_id++;
        check_val("rd_out_same_cycle", rd_outstanding, 1);
        check_val("no_err_yet", proto_err, 0);
        rbeat(8'd5, 64'h55, 1'b1, 1'b1, 1'b0);
        check_val("rd_out_zero", rd_outstanding, 0);
        check_val("no_err_still", proto_err, 0);
        rbeat(8'd9, 64'h99, 1'b1, 1'b1, 1'b0);
        check_val("err_stray_beat", proto_err, 1);
        check_val("rd_out_stays0", rd_outstanding, 0);

        // asynchronous reset clears everything without a clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("arst_proto_err", proto_err, 0);
        check_val("arst_rd_ready", bus.itf_rd_data_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_id = 8'd0;
        @(posedge clk);
        #1;

        // size-0 request is swallowed and flagged
        req(1, 33'h600, 3'd0);
        check_val("size0_err", proto_err, 1);
        check_val("size0_no_cmd", bus.itf_cmd_valid, 0);
        check_val("size0_idle", bus.usr_req_ready, 1);
        @(posedge clk);
        #1;
        check_val("size0_no_cmd2", bus.itf_cmd_valid, 0);

        // 257 single-beat writes walk the ID counter through its wrap
        for (int k = 0; k < 257; k++) begin
            req(1, AW'(k * 64), 3'd1);
            if (k == 255) check_val("id_255", bus.itf_cmd_id, 8'd255);
            if (k == 256) check_val("id_wrap", bus.itf_cmd_id, 8'd0);
            cmd_expect(1, AW'(k * 64), 3'd1);
            cmd_take();
            wbeats(1, 1'b0, exp_id - 8'd1);
        end
        check_val("final_proto_err", proto_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
